sub48_pipe: RTL and testbench

Pipelined 48-bit subtractor (D = A - B - bin) with a borrow-in and a borrow-out. It is the inverse-operation companion of the 48-bit ripple adder. The borrow chain is cut into three 16-bit slice stages with a register between each stage, so timing stays within one 16-bit slice. A valid/ready handshake on both sides lets it sit in the FASM datapath between operand staging and the result writeback.

---
 rtl/sub48_pkg.sv | 7 +
 rtl/sub16_slice.sv | 22 ++
 rtl/sub48_pipe.sv | 118 +++++++++++
 tb/tb_sub48_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub48_pkg.sv
// Shared widths and pipeline depth for the 48-bit pipelined subtractor.
package sub48_pkg;
  localparam int unsigned SLICE_W    = 16;
  localparam int unsigned NUM_SLICES = 3;
  localparam int unsigned W          = SLICE_W * NUM_SLICES;
  localparam int unsigned LAT        = 3;
endpackage

// File: rtl/sub16_slice.sv
// Combinational 16-bit slice computing a + ~b + cin; c15 is the carry into the MSB.
module sub16_slice
  import sub48_pkg::*;
(
  input  logic [SLICE_W:1] a,
  input  logic [SLICE_W:1] b,
  input  logic             cin,
  output logic [SLICE_W:1] s,
  output logic             cout,
  output logic             c15
);
  logic [SLICE_W-1:0] w_lo;
  logic               w_nb;

  // Lower SLICE_W-1 bits plus one spare bit to capture the carry into the MSB.
  assign w_lo = {1'b0, a[SLICE_W-1:1]} + {1'b0, ~b[SLICE_W-1:1]}
              + {{(SLICE_W-1){1'b0}}, cin};
  assign c15  = w_lo[SLICE_W-1];
  assign w_nb = ~b[SLICE_W];
  assign s    = {a[SLICE_W] ^ w_nb ^ c15, w_lo[SLICE_W-2:0]};
  assign cout = (a[SLICE_W] & w_nb) | (a[SLICE_W] & c15) | (w_nb & c15);
endmodule

// File: rtl/sub48_pipe.sv
// Three-stage pipelined 48-bit subtractor D = A - B - bin with valid/ready handshake.
// Optional signed-overflow output enabled by defining SUB48_OVF_EN.
module sub48_pipe
  import sub48_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:1]   A,
  input  logic [W:1]   B,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:1]   D,
  output logic         bout
`ifdef SUB48_OVF_EN
  ,
  output logic         ovf
`endif
);
  logic             w_adv1, w_adv2, w_adv3;
  logic [SLICE_W:1] w_s0, w_s1, w_s2;
  logic             w_c16, w_c32, w_c48;
  logic             w_c15_0, w_c15_1, w_c47;

  logic             r_v1, r_v2, r_v3;
  logic [16:1]      r_s1;
  logic             r_c16;
  logic [48:17]     r_a1, r_b1;
  logic [32:1]      r_s2;
  logic             r_c32;
  logic [48:33]     r_a2, r_b2;
  logic [48:1]      r_d;
  logic             r_bout;

  // Each stage moves when its register is empty or its consumer takes the contents.
  assign w_adv3   = ~r_v3 | out_ready;
  assign w_adv2   = ~r_v2 | w_adv3;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign in_ready = w_adv1;

  sub16_slice u_slice0 (.a(A[16:1]),     .b(B[16:1]),     .cin(~bin),
                        .s(w_s0), .cout(w_c16), .c15(w_c15_0));
  sub16_slice u_slice1 (.a(r_a1[32:17]), .b(r_b1[32:17]), .cin(r_c16),
                        .s(w_s1), .cout(w_c32), .c15(w_c15_1));
  sub16_slice u_slice2 (.a(r_a2[48:33]), .b(r_b2[48:33]), .cin(r_c32),
                        .s(w_s2), .cout(w_c48), .c15(w_c47));

  // Data registers load only on a real transfer so idle-bus X never reaches D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_s1  <= '0;
      r_c16 <= 1'b0;
      r_a1  <= '0;
      r_b1  <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1  <= w_s0;
        r_c16 <= w_c16;
        r_a1  <= A[48:17];
        r_b1  <= B[48:17];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_s2  <= '0;
      r_c32 <= 1'b0;
      r_a2  <= '0;
      r_b2  <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2  <= {w_s1, r_s1};
        r_c32 <= w_c32;
        r_a2  <= r_a1[48:33];
        r_b2  <= r_b1[48:33];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_d    <= {w_s2, r_s2};
        r_bout <= ~w_c48;
      end
    end
  end

`ifdef SUB48_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv3 && r_v2) begin
      r_ovf <= w_c47 ^ w_c48;
    end
  end

  assign ovf = r_ovf;
`endif

  assign out_valid = r_v3;
  assign D         = r_d;
  assign bout      = r_bout;
endmodule

// File: tb/tb_sub48_pipe.sv
// Self-checking bench for sub48_pipe: directed table, backpressure, mid-flight reset, random.
module tb_sub48_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [48:1] A, B, D;
`ifdef SUB48_OVF_EN
  logic        ovf;
`endif

  sub48_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .bout(bout)
`ifdef SUB48_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] a;
    logic [47:0] b;
    logic        bi;
    logic [47:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [47:0] d;
    logic        bo;
    logic        ov;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t nxt_exp;
  int   nchk = 0;
  int   nfail = 0;
  int   cyc = 0;
  bit   acc, drn, chk_lat;

  // Reference: plain integer arithmetic on the mathematical definitions.
  function automatic exp_t model(logic [47:0] a, logic [47:0] b, logic bi);
    exp_t   e;
    longint sa, sb, sr;
    e.d  = a - b - 48'(bi);
    e.bo = ({16'd0, a} < ({16'd0, b} + 64'(bi)));
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sr   = sa - sb - longint'(bi);
    e.ov = (sr > 64'sh7FFF_FFFF_FFFF) || (sr < -64'sh8000_0000_0000);
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      if (q.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL spurious_out actual D=%h bout=%b required no output", D, bout);
      end else begin
        e = q.pop_front();
        check("D", 64'(D), 64'(e.d));
        check("bout", 64'(bout), 64'(e.bo));
`ifdef SUB48_OVF_EN
        check("ovf", 64'(ovf), 64'(e.ov));
`endif
        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
    if (acc) begin
      e = nxt_exp;
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    check(name, 64'(q.size()), 64'd0);
  endtask

  task automatic set_op(logic [47:0] a, logic [47:0] b, logic bi);
    A = a;
    B = b;
    bin = bi;
    nxt_exp = model(a, b, bi);
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{48'h000000000005, 48'h000000000003, 1'b0, 48'h000000000002, 1'b0, 1'b0};
    vt[1] = '{48'h000000000000, 48'h000000000001, 1'b0, 48'hFFFFFFFFFFFF, 1'b1, 1'b0};
    vt[2] = '{48'h000000010000, 48'h000000000000, 1'b1, 48'h00000000FFFF, 1'b0, 1'b0};
    vt[3] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 48'hFFFFFFFFFFFF, 1'b1, 1'b0};
    vt[4] = '{48'h800000000000, 48'h000000000001, 1'b0, 48'h7FFFFFFFFFFF, 1'b0, 1'b1};
    vt[5] = '{48'h7FFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 48'h800000000000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; bin = 1'b0;
    chk_lat = 1'b0;
    nxt_exp = model(48'd0, 48'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_D", 64'(D), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed table: one op at a time, checking values and 3-cycle latency.
    chk_lat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      A = vt[i].a; B = vt[i].b; bin = vt[i].bi;
      nxt_exp.d = vt[i].d; nxt_exp.bo = vt[i].bo; nxt_exp.ov = vt[i].ov;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) step();
      check("vec_accept", 64'(acc), 64'd1);
      drain("vec_drain");
    end

    // Back-to-back throughput with out_ready high.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(48'(i * 1000 + 7), 48'(i * 3), i[0]);
      step();
      check("b2b_accept", 64'(acc), 64'd1);
    end
    drain("b2b_drain");
    chk_lat = 1'b0;

    // Backpressure: exactly 3 accepted, D stable while stalled, then in-order drain.
    begin
      logic [48:1] held;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        set_op(48'(100 + i), 48'(i), 1'b0);
        step();
        check("bp_accept", 64'(acc), 64'(i < 3));
      end
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      held = D;
      repeat (3) begin
        step();
        check("bp_D_stable", 64'(D), 64'(held));
        check("bp_stall_accept", 64'(acc), 64'd0);
      end
      out_ready = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) step();
      check("bp_4th_accept", 64'(acc), 64'd1);
      drain("bp_drain");
    end

    // Mid-flight reset: discard everything, no stale output afterwards.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_op(48'd100, 48'd1, 1'b0);
    step();
    set_op(48'd200, 48'd2, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mr_out_valid_pre", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_D", 64'(D), 64'd0);
    check("mr_bout", 64'(bout), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    repeat (8) step();
    check("mr_no_stale", 64'(out_valid), 64'd0);

    // Randomized traffic with random backpressure against the model.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = 64'hFFFF_FFFF_FFFF;
        1: rb = 64'hFFFF_FFFF_FFFF;
        2: rb = ra;
        default: ;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_op(ra[47:0], rb[47:0], 1'($urandom_range(0, 1)));
      step();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
